// File: rtl/mips_control_decode_if.sv
// Decoder bundle: capture controls, instruction fields, and the
// registered decode outputs of mips_control_decode.
interface mips_control_decode_if;
  logic       en;
  logic       flush;
  logic [5:0] op;
  logic [5:0] func;
  logic [3:0] aluop;
  logic       jal;
  logic       lw;
  logic       sw;
  logic       beq;
  logic       bne;
  logic       j;
  logic       lh;
  logic       bltz;
  logic       jr;
  logic       rtype;
  logic       reg_write;
  logic       reg_dst_rd;
  logic       alu_src_imm;
  logic       zero_ext;
  logic       shift_shamt;
  logic       illegal;
  logic       out_valid;

  modport master (
    output en, flush, op, func,
    input  aluop, jal, lw, sw, beq, bne, j, lh, bltz, jr,
    input  rtype, reg_write, reg_dst_rd, alu_src_imm,
    input  zero_ext, shift_shamt, illegal, out_valid
  );

  modport slave (
    input  en, flush, op, func,
    output aluop, jal, lw, sw, beq, bne, j, lh, bltz, jr,
    output rtype, reg_write, reg_dst_rd, alu_src_imm,
    output zero_ext, shift_shamt, illegal, out_valid
  );
endinterface

// File: rtl/mips_control_decode.sv
// Registered MIPS-subset control decoder: op/func in, ALU code,
// instruction strobes and datapath selects out one cycle later.
module mips_control_decode (
  input logic clk,
  input logic rst_n,
  mips_control_decode_if.slave bus
);

  typedef struct packed {
    logic [3:0] aluop;
    logic       jal;
    logic       lw;
    logic       sw;
    logic       beq;
    logic       bne;
    logic       j;
    logic       lh;
    logic       bltz;
    logic       jr;
    logic       rtype;
    logic       reg_write;
    logic       reg_dst_rd;
    logic       alu_src_imm;
    logic       zero_ext;
    logic       shift_shamt;
    logic       illegal;
  } ctl_t;

  localparam logic [3:0] ALU_SLL  = 4'd0;
  localparam logic [3:0] ALU_SRA  = 4'd1;
  localparam logic [3:0] ALU_SRL  = 4'd2;
  localparam logic [3:0] ALU_ADD  = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_AND  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_XOR  = 4'd9;
  localparam logic [3:0] ALU_NOR  = 4'd10;
  localparam logic [3:0] ALU_SLT  = 4'd11;
  localparam logic [3:0] ALU_SLTU = 4'd12;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_BLTZ  = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_JR   = 6'b001000;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;

  ctl_t ctl_d;
  ctl_t ctl_q;
  logic out_valid_q;

  always_comb begin
    ctl_d       = '0;
    ctl_d.aluop = ALU_ADD;
    unique case (bus.op)
      OP_R: begin
        ctl_d.rtype      = 1'b1;
        ctl_d.reg_write  = 1'b1;
        ctl_d.reg_dst_rd = 1'b1;
        unique case (bus.func)
          F_ADD, F_ADDU: ctl_d.aluop = ALU_ADD;
          F_SUB:  ctl_d.aluop = ALU_SUB;
          F_AND:  ctl_d.aluop = ALU_AND;
          F_OR:   ctl_d.aluop = ALU_OR;
          F_NOR:  ctl_d.aluop = ALU_NOR;
          F_SLT:  ctl_d.aluop = ALU_SLT;
          F_SLTU: ctl_d.aluop = ALU_SLTU;
          F_SLL: begin
            ctl_d.aluop       = ALU_SLL;
            ctl_d.shift_shamt = 1'b1;
          end
          F_SRL: begin
            ctl_d.aluop       = ALU_SRL;
            ctl_d.shift_shamt = 1'b1;
          end
          F_SRA: begin
            ctl_d.aluop       = ALU_SRA;
            ctl_d.shift_shamt = 1'b1;
          end
          F_JR: begin
            ctl_d.jr         = 1'b1;
            ctl_d.reg_write  = 1'b0;
            ctl_d.reg_dst_rd = 1'b0;
          end
          default: begin
            ctl_d.illegal    = 1'b1;
            ctl_d.reg_write  = 1'b0;
            ctl_d.reg_dst_rd = 1'b0;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI: begin
        ctl_d.alu_src_imm = 1'b1;
        ctl_d.reg_write   = 1'b1;
        if (bus.op == OP_SLTI) ctl_d.aluop = ALU_SLT;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        ctl_d.alu_src_imm = 1'b1;
        ctl_d.reg_write   = 1'b1;
        ctl_d.zero_ext    = 1'b1;
        ctl_d.aluop = (bus.op == OP_ANDI) ? ALU_AND :
                      (bus.op == OP_ORI)  ? ALU_OR  : ALU_XOR;
      end
      OP_LW: begin
        ctl_d.lw          = 1'b1;
        ctl_d.alu_src_imm = 1'b1;
        ctl_d.reg_write   = 1'b1;
      end
      OP_LH: begin
        ctl_d.lh          = 1'b1;
        ctl_d.alu_src_imm = 1'b1;
        ctl_d.reg_write   = 1'b1;
      end
      OP_SW: begin
        ctl_d.sw          = 1'b1;
        ctl_d.alu_src_imm = 1'b1;
      end
      OP_BEQ: begin
        ctl_d.beq   = 1'b1;
        ctl_d.aluop = ALU_SUB;
      end
      OP_BNE: begin
        ctl_d.bne   = 1'b1;
        ctl_d.aluop = ALU_SUB;
      end
      OP_BLTZ: begin
        ctl_d.bltz  = 1'b1;
        ctl_d.aluop = ALU_SLT;
      end
      OP_J: ctl_d.j = 1'b1;
      // jal writes $31; the register file picks that from the strobe
      OP_JAL: begin
        ctl_d.jal       = 1'b1;
        ctl_d.reg_write = 1'b1;
      end
      default: ctl_d.illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (bus.flush) begin
      ctl_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (bus.en) begin
      ctl_q       <= ctl_d;
      out_valid_q <= 1'b1;
    end
  end

  assign bus.aluop       = ctl_q.aluop;
  assign bus.jal         = ctl_q.jal;
  assign bus.lw          = ctl_q.lw;
  assign bus.sw          = ctl_q.sw;
  assign bus.beq         = ctl_q.beq;
  assign bus.bne         = ctl_q.bne;
  assign bus.j           = ctl_q.j;
  assign bus.lh          = ctl_q.lh;
  assign bus.bltz        = ctl_q.bltz;
  assign bus.jr          = ctl_q.jr;
  assign bus.rtype       = ctl_q.rtype;
  assign bus.reg_write   = ctl_q.reg_write;
  assign bus.reg_dst_rd  = ctl_q.reg_dst_rd;
  assign bus.alu_src_imm = ctl_q.alu_src_imm;
  assign bus.zero_ext    = ctl_q.zero_ext;
  assign bus.shift_shamt = ctl_q.shift_shamt;
  assign bus.illegal     = ctl_q.illegal;
  assign bus.out_valid   = out_valid_q;

endmodule

// File: tb/tb_mips_control_decode.sv
// Directed-vector bench for mips_control_decode: decode table sweep
// plus hold, flush-over-enable and asynchronous reset sequences.
module tb_mips_control_decode;

  logic clk = 1'b0;
  logic rst_n;

  mips_control_decode_if bus ();

  mips_control_decode dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  localparam logic [15:0] JAL = 16'h8000;
  localparam logic [15:0] LW  = 16'h4000;
  localparam logic [15:0] SW  = 16'h2000;
  localparam logic [15:0] BEQ = 16'h1000;
  localparam logic [15:0] BNE = 16'h0800;
  localparam logic [15:0] J   = 16'h0400;
  localparam logic [15:0] LH  = 16'h0200;
  localparam logic [15:0] BLZ = 16'h0100;
  localparam logic [15:0] JR  = 16'h0080;
  localparam logic [15:0] RT  = 16'h0040;
  localparam logic [15:0] RW  = 16'h0020;
  localparam logic [15:0] RD  = 16'h0010;
  localparam logic [15:0] ASI = 16'h0008;
  localparam logic [15:0] ZX  = 16'h0004;
  localparam logic [15:0] SH  = 16'h0002;
  localparam logic [15:0] ILL = 16'h0001;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] func;
    logic [3:0] aluop;
    logic [15:0] flags;
  } vec_t;

  vec_t vt[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [15:0] got_flags();
    return {bus.jal, bus.lw, bus.sw, bus.beq, bus.bne, bus.j,
            bus.lh, bus.bltz, bus.jr, bus.rtype, bus.reg_write,
            bus.reg_dst_rd, bus.alu_src_imm, bus.zero_ext,
            bus.shift_shamt, bus.illegal};
  endfunction

  task automatic check(input string nm, input logic [3:0] ea,
                       input logic [15:0] ef, input logic ev);
    logic [15:0] gf;
    gf = got_flags();
    n_tests++;
    if (bus.aluop !== ea || gf !== ef || bus.out_valid !== ev) begin
      n_fail++;
      $display("FAIL %s: got aluop=%0d flags=%h valid=%b, want aluop=%0d flags=%h valid=%b",
               nm, bus.aluop, gf, bus.out_valid, ea, ef, ev);
    end
  endtask

  task automatic capture(input logic [5:0] o, input logic [5:0] f);
    @(negedge clk);
    bus.op = o;
    bus.func = f;
    bus.en = 1'b1;
    bus.flush = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vt.push_back('{"addi",  6'b001000, 6'b000000, 4'd5,  ASI | RW});
    vt.push_back('{"addiu", 6'b001001, 6'b000000, 4'd5,  ASI | RW});
    vt.push_back('{"andi",  6'b001100, 6'b000000, 4'd7,  ASI | ZX | RW});
    vt.push_back('{"ori",   6'b001101, 6'b000000, 4'd8,  ASI | ZX | RW});
    vt.push_back('{"lw",    6'b100011, 6'b000000, 4'd5,  LW | ASI | RW});
    vt.push_back('{"sw",    6'b101011, 6'b000000, 4'd5,  SW | ASI});
    vt.push_back('{"beq",   6'b000100, 6'b000000, 4'd6,  BEQ});
    vt.push_back('{"bne",   6'b000101, 6'b000000, 4'd6,  BNE});
    vt.push_back('{"slti",  6'b001010, 6'b000000, 4'd11, ASI | RW});
    vt.push_back('{"xori",  6'b001110, 6'b000000, 4'd9,  ASI | ZX | RW});
    vt.push_back('{"lh",    6'b100001, 6'b000000, 4'd5,  LH | ASI | RW});
    vt.push_back('{"bltz",  6'b000001, 6'b000000, 4'd11, BLZ});
    vt.push_back('{"j",     6'b000010, 6'b000000, 4'd5,  J});
    vt.push_back('{"jal",   6'b000011, 6'b000000, 4'd5,  JAL | RW});
    vt.push_back('{"addi_func_ignored", 6'b001000, 6'b100010, 4'd5, ASI | RW});
    vt.push_back('{"add",   6'b000000, 6'b100000, 4'd5,  RT | RW | RD});
    vt.push_back('{"addu",  6'b000000, 6'b100001, 4'd5,  RT | RW | RD});
    vt.push_back('{"sub",   6'b000000, 6'b100010, 4'd6,  RT | RW | RD});
    vt.push_back('{"and",   6'b000000, 6'b100100, 4'd7,  RT | RW | RD});
    vt.push_back('{"or",    6'b000000, 6'b100101, 4'd8,  RT | RW | RD});
    vt.push_back('{"nor",   6'b000000, 6'b100111, 4'd10, RT | RW | RD});
    vt.push_back('{"slt",   6'b000000, 6'b101010, 4'd11, RT | RW | RD});
    vt.push_back('{"sltu",  6'b000000, 6'b101011, 4'd12, RT | RW | RD});
    vt.push_back('{"sll",   6'b000000, 6'b000000, 4'd0,  RT | RW | RD | SH});
    vt.push_back('{"srl",   6'b000000, 6'b000010, 4'd2,  RT | RW | RD | SH});
    vt.push_back('{"sra",   6'b000000, 6'b000011, 4'd1,  RT | RW | RD | SH});
    vt.push_back('{"jr",    6'b000000, 6'b001000, 4'd5,  RT | JR});
    vt.push_back('{"ill_func", 6'b000000, 6'b000111, 4'd5, RT | ILL});
    vt.push_back('{"ill_op",   6'b010000, 6'b000000, 4'd5, ILL});

    rst_n = 1'b0;
    bus.en = 1'b0;
    bus.flush = 1'b0;
    bus.op = 6'b001000;
    bus.func = 6'b000000;
    repeat (2) @(posedge clk);
    #1 check("reset", 4'd0, 16'h0000, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 check("idle_after_reset", 4'd0, 16'h0000, 1'b0);

    foreach (vt[i]) begin
      capture(vt[i].op, vt[i].func);
      check(vt[i].name, vt[i].aluop, vt[i].flags, 1'b1);
    end

    capture(6'b100011, 6'b000000);
    check("hold_load", 4'd5, LW | ASI | RW, 1'b1);
    @(negedge clk);
    bus.en = 1'b0;
    bus.op = 6'b000100;
    repeat (2) @(posedge clk);
    #1 check("hold", 4'd5, LW | ASI | RW, 1'b1);

    @(negedge clk);
    bus.en = 1'b1;
    bus.flush = 1'b1;
    bus.op = 6'b001101;
    @(posedge clk);
    #1 check("flush_over_en", 4'd0, 16'h0000, 1'b0);

    capture(6'b001101, 6'b000000);
    check("ori_before_rst", 4'd8, ASI | ZX | RW, 1'b1);
    @(negedge clk);
    bus.en = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("async_reset", 4'd0, 16'h0000, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    capture(6'b000011, 6'b000000);
    check("jal_after_rst", 4'd5, JAL | RW, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mips_control_decode.md
# mips_control_decode

Registered control decoder for the single-issue MIPS-subset CPU. It sits between instruction fetch and the register file/ALU. It takes the opcode and function fields of the fetched instruction and produces a 4-bit ALU operation code, the per-instruction decode strobes (jal, lw, sw, beq, bne, j, lh, bltz) and the datapath select signals. All outputs are registered and appear one cycle after capture.

## Interface
No parameters.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  capture enable; low holds all outputs
- flush  in  1  synchronous clear to the reset state (bubble); has priority over en
- op  in  6  instruction[31:26]
- func  in  6  instruction[5:0]; ignored unless op = 000000
- aluop  out  4  ALU operation code
- jal, lw, sw, beq, bne, j, lh, bltz  out  1 each  one-hot instruction strobes
- jr  out  1  R-type jr
- rtype  out  1  op = 000000
- reg_write  out  1  instruction writes the register file
- reg_dst_rd  out  1  destination is rd (R-type); otherwise rt, or $31 for jal
- alu_src_imm  out  1  ALU B operand is the extended immediate
- zero_ext  out  1  immediate is zero-extended (else sign-extended)
- shift_shamt  out  1  shift uses the shamt field
- illegal  out  1  opcode/func not in the supported set
- out_valid  out  1  registered copy of en that was applied (0 after reset or flush)

## Operation
The ALU code is the same as the ALU's own code: 0 sll, 1 sra, 2 srl, 3 mul, 4 div, 5 add, 6 sub, 7 and, 8 or, 9 xor, 10 nor, 11 slt, 12 sltu.

R-type (op = 000000), func gives aluop:
- add 100000 and addu 100001 -> 5
- sub 100010 -> 6
- and 100100 -> 7
- or 100101 -> 8
- nor 100111 -> 10
- slt 101010 -> 11
- sltu 101011 -> 12
- sll 000000 -> 0, srl 000010 -> 2, sra 000011 -> 1 (all three set shift_shamt)
- jr 001000 -> 5 (sets jr, reg_write = 0)
- Any other func (for example 000111) -> aluop 5, illegal = 1, reg_write = 0.
- Legal non-jr R-type: reg_write = 1, reg_dst_rd = 1.

I/J-type, op gives aluop:
- addi 001000 and addiu 001001 -> 5
- andi 001100 -> 7
- ori 001101 -> 8
- xori 001110 -> 9
- slti 001010 -> 11
- lw 100011, sw 101011 and lh 100001 -> 5
- beq 000100 and bne 000101 -> 6
- bltz 000001 -> 11 (compare against zero)
- j 000010 and jal 000011 -> 5
- Any other op (for example 010000) -> aluop 5, illegal = 1, all strobes and enables 0.

Select signals:
- alu_src_imm = 1 for addi, addiu, andi, ori, xori, slti, lw, sw, lh.
- zero_ext = 1 for andi, ori, xori.
- reg_write = 1 for addi, addiu, andi, ori, xori, slti, lw, lh, jal.
- All other signals not listed for an instruction are 0.
- Exactly one of the strobes jal, lw, sw, beq, bne, j, lh, bltz, jr may be 1; none is 1 for arithmetic instructions.

## Timing
- Reset (async, rst_n low): all outputs 0, including aluop = 0 and out_valid = 0. Outputs are released on the first clk edge after rst_n rises.
- On each rising clk edge:
  - flush = 1: outputs go to the reset values.
  - else en = 1: outputs are loaded from the combinational decode of op/func; out_valid = 1.
  - else: all outputs hold.
- Latency: one cycle from op/func to outputs. Back-to-back captures are allowed every cycle.
- flush and en high together: flush wins.
- Reset asserted during a capture: reset wins immediately.

## Test plan
- Reset, then en = 1 with op = 001000 -> next cycle aluop = 5, alu_src_imm = 1, reg_write = 1, illegal = 0, out_valid = 1.
- Sweep the I/J ops 001001, 001100, 001101, 100011, 101011, 000100, 000101, 001010, 001110, 100001, 000001, 000010, 000011 -> aluop 5, 7, 8, 5, 5, 6, 6, 11, 9, 5, 11, 5, 5, with the matching single strobe (lw, sw, beq, bne, lh, bltz, j, jal) and zero_ext only for 001100, 001101 and 001110.
- op = 0, sweep func 100000, 100001, 100010, 100100, 100101, 100111, 101010, 101011, 0, 2, 3, 001000 -> aluop 5, 5, 6, 7, 8, 10, 11, 12, 0, 2, 1, 5; shift_shamt only for the shifts; jr only for 001000.
- Illegal codes: op = 0 with func = 000111, and op = 010000 -> illegal = 1, reg_write = 0, aluop = 5, all strobes 0.
- Hold and flush: capture lw, then en = 0 with op changed -> outputs stay at lw; then assert flush and en together -> all outputs 0, out_valid = 0.
- Assert rst_n low between clock edges while outputs are nonzero -> outputs clear without waiting for a clock edge.
